// File: rtl/serial_shift_tx_pkg.sv
// Shared definitions for the serial link: FSM state encodings, line levels, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_shift_tx_pkg;

  // Frame FSM encodings; receive-side blocks decode the same values.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Line levels: the link idles at mark, the start bit is a space.
  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while enabled, tick on the last count of each bit period.
// Latency: tick is combinational from the count register; count wraps on the clock after tick.
// Backpressure: none; clr holds the count at zero.
module serial_bit_timer
  import serial_shift_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Modulo-DIV count; for DIV=1 the count stays at zero and tick is permanently high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-in serial-out transmitter: start bit, WIDTH data bits LSB-first, optional parity, stop bit.
// Latency: word captured at edge N drives the start bit from edge N+1; frame is (WIDTH+2[+1])*DIV clocks.
// Backpressure: ready only in IDLE or on the last clock of STOP; valid while !ready is ignored.
// Build option SERIAL_SHIFT_TX_PARITY_EN inserts an even-parity bit between data and stop.
module serial_shift_tx
  import serial_shift_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             valid,
  output logic             ready,
  output logic             busy,
  output logic             sout
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             tick;
  logic             fire;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
  logic             par;
`endif

  // Divider runs only while a frame is in flight and sits at zero in IDLE.
  serial_bit_timer #(.DIV(DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  // Accepting on STOP's final clock lets frames run back to back with no idle gap.
  assign ready = (state == ST_IDLE) || ((state == ST_STOP) && tick);
  assign fire  = valid && ready;
  assign busy  = (state != ST_IDLE);

  // State register; async reset aborts any frame and returns the line to mark at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing and the line level for the current state.
  always_comb begin
    state_nxt = state;
    sout      = MARK;
    case (state)
      ST_IDLE: begin
        sout = MARK;
        if (fire) state_nxt = ST_START;
      end
      ST_START: begin
        sout = SPACE;
        if (tick) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        sout = shreg[0];
        if (tick && (bitcnt == LAST_BIT)) begin
`ifdef SERIAL_SHIFT_TX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_SHIFT_TX_PARITY_EN
      ST_PARITY: begin
        sout = par;
        if (tick) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        sout = MARK;
        if (tick) state_nxt = fire ? ST_START : ST_IDLE;
      end
      default: begin
        sout      = MARK;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word capture and LSB-first shifting; d is only sampled on an accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (fire) begin
      shreg  <= d;
      bitcnt <= '0;
    end else if ((state == ST_DATA) && tick) begin
      shreg  <= shreg >> 1;
      bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + BW'(1);
    end
  end

`ifdef SERIAL_SHIFT_TX_PARITY_EN
  // Parity comes from the word as captured, since the shift register is consumed by DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       par <= 1'b0;
    else if (fire) par <= ^d;
  end
`endif

endmodule

// File: tb/tb_serial_shift_tx.sv
// Self-checking bench for serial_shift_tx: per-clock scoreboard of line levels plus directed frames.
// Main DUT WIDTH=8 DIV=4; a second DUT with DIV=1 covers the single-clock-per-bit case.
// Honours SERIAL_SHIFT_TX_PARITY_EN when building expected frames.
module tb_serial_shift_tx;

  localparam int W  = 8;
  localparam int DV = 4;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [10:0] E1 = 11'b100_1010_1010;
`else
  localparam int PB = 0;
  localparam logic [10:0] E1 = 11'b000_1010_1010 | 11'b010_0000_0000;
`endif
  localparam int NB = W + 2 + PB;
  localparam int FL = NB * DV;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] d      = 8'hxx;
  logic       valid  = 1'b0;
  logic       ready, busy, sout;
  logic [7:0] d1     = 8'h00;
  logic       valid1 = 1'b0;
  logic       ready1, busy1, sout1;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mq[$];
  logic acc;
  logic seen[FL];

  typedef struct {
    logic [7:0] d;
    logic       exp_par;
    bit         intrude;
  } vec_t;
  vec_t tbl[6];

  serial_shift_tx #(.WIDTH(W), .DIV(DV)) dut (
    .clk(clk), .rst(rst), .d(d), .valid(valid), .ready(ready), .busy(busy), .sout(sout)
  );

  serial_shift_tx #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .d(d1), .valid(valid1), .ready(ready1), .busy(busy1), .sout(sout1)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a frame is just the list of line levels, each held for DV clocks.
  task automatic push_frame(input logic [7:0] w);
    logic fr[NB];
    fr[0] = 1'b0;
    for (int i = 0; i < W; i++) fr[i+1] = w[i];
    if (PB != 0) fr[W+1] = ^w;
    fr[NB-1] = 1'b1;
    for (int i = 0; i < NB; i++)
      for (int k = 0; k < DV; k++) mq.push_back(fr[i]);
  endtask

  // Compare current outputs with the queue, then advance one clock.
  // The transmitter is ready when at most one clock of the current frame remains.
  task automatic step();
    chk("sout",  {31'd0, sout},  {31'd0, (mq.size() != 0) ? mq[0] : 1'b1});
    chk("ready", {31'd0, ready}, {31'd0, mq.size() <= 1});
    chk("busy",  {31'd0, busy},  {31'd0, mq.size() != 0});
    acc = valid && (mq.size() <= 1);
    if (mq.size() != 0) void'(mq.pop_front());
    if (acc) push_frame(d);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && mq.size() != 0; i++) step();
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] w, input bit intrude, input logic exp_par);
    int         nbusy;
    logic [7:0] got;
    wait_idle();
    d = w; valid = 1'b1;
    step();
    chk("accept", {31'd0, acc}, 32'd1);
    valid = 1'b0; d = 8'($urandom);
    nbusy = 0;
    for (int j = 0; j < FL; j++) begin
      if (intrude && j == 15) begin valid = 1'b1; d = 8'h3C; end
      if (intrude && j == 25) valid = 1'b0;
      seen[j] = sout;
      if (busy) nbusy++;
      if (j == FL - 1) chk("ready_last_stop", {31'd0, ready}, 32'd1);
      step();
    end
    chk("busy_clks", nbusy, FL);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("start_bit", {31'd0, seen[DV/2]}, 32'd0);
    for (int i = 0; i < W; i++) got[i] = seen[(i+1)*DV + DV/2];
    chk("data_bits", {24'd0, got}, {24'd0, w});
    if (PB != 0) chk("parity_bit", {31'd0, seen[(W+1)*DV + DV/2]}, {31'd0, exp_par});
    chk("stop_bit", {31'd0, seen[(NB-1)*DV + DV/2]}, 32'd1);
  endtask

  initial begin
    int         nacc, nb;
    logic [10:0] e1;
    tbl[0] = '{8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 1'b1, 1'b0};
    tbl[2] = '{8'hA5, 1'b0, 1'b1};
    tbl[3] = '{8'h81, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 1'b1, 1'b0};

    // Reset with the clock stopped and d undriven.
    #2;
    chk("rst_sout",  {31'd0, sout},  32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_sout1", {31'd0, sout1}, 32'd1);
    #3 rst = 1'b0;
    clk_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) step();
    d = 8'h00;

    // Directed frames, including a mid-frame valid that must be ignored.
    foreach (tbl[i]) send_frame(tbl[i].d, tbl[i].intrude, tbl[i].exp_par);

    // valid held: two frames back to back with no idle clock.
    wait_idle();
    valid = 1'b1; d = 8'h00; nacc = 0; nb = 0;
    for (int j = 0; j < 2*FL + 4; j++) begin
      if (j >= 1 && j <= 2*FL && busy) nb++;
      if (j == FL)     chk("b2b_stop",  {31'd0, sout}, 32'd1);
      if (j == FL + 1) chk("b2b_start", {31'd0, sout}, 32'd0);
      step();
      if (acc) begin
        nacc++;
        d = 8'hFF;
        if (nacc == 2) valid = 1'b0;
      end
    end
    chk("b2b_accepts", nacc, 2);
    chk("b2b_busy", nb, 2*FL);

    // Async reset during data bit 3, then a clean frame.
    wait_idle();
    d = 8'h5A; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int j = 0; j < 17; j++) step();
    #3 rst = 1'b1;
    #1;
    chk("arst_sout",  {31'd0, sout},  32'd1);
    chk("arst_busy",  {31'd0, busy},  32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    mq.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send_frame(8'h81, 1'b0, 1'b0);

    // DIV=1 instance: one clock per bit, ready high in the STOP cycle.
    e1 = E1;
    d1 = 8'h55; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0; d1 = 8'hC3;
    for (int j = 0; j < NB; j++) begin
      chk("div1_sout",  {31'd0, sout1},  {31'd0, e1[j]});
      chk("div1_busy",  {31'd0, busy1},  32'd1);
      chk("div1_ready", {31'd0, ready1}, {31'd0, j == NB - 1});
      @(posedge clk); #1;
    end
    chk("div1_idle", {31'd0, busy1}, 32'd0);

    // Random valid/data traffic against the queue model.
    for (int c = 0; c < 1500; c++) begin
      valid = ($urandom_range(0, 2) == 0);
      d     = 8'($urandom);
      step();
    end
    valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
